// File: rtl/frame_config_mem_shadow.sv
// Shadowed tile configuration memory: frames load into a shadow array and reach
// the live ConfigBits only on an explicit commit. A handshaked port reads back shadow frames.
module frame_config_mem_shadow #(
    parameter int                      MaxFramesPerCol  = 20,
    parameter int                      FrameBitsPerRow  = 32,
    parameter int                      NoConfigBits     = 64,
    parameter bit                      EMULATION_ENABLE = 1'b0,
    parameter logic [NoConfigBits-1:0] EMULATION_CONFIG = '0,
    localparam int NoFrames = (NoConfigBits + FrameBitsPerRow - 1) / FrameBitsPerRow,
    localparam int RbW      = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    input  logic                       commit,
    input  logic                       rb_req,
    input  logic [RbW-1:0]             rb_frame,
    output logic                       rb_busy,
    output logic                       rb_valid,
    output logic [FrameBitsPerRow-1:0] rb_data,
    output logic                       rb_err,
    output logic [NoFrames-1:0]        frame_loaded,
    output logic                       all_loaded,
    output logic [NoConfigBits-1:0]    ConfigBits,
    output logic [NoConfigBits-1:0]    ConfigBits_N
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} rb_state_t;

    logic [NoFrames-1:0]                      r_strobe_q;
    logic [NoFrames-1:0]                      w_rise;
    logic [NoFrames-1:0][FrameBitsPerRow-1:0] w_frame;
    logic                                     w_unused;

    // Strobes beyond the last real frame never reach the edge detector.
    assign w_rise   = FrameStrobe[NoFrames-1:0] & ~r_strobe_q;
    assign w_unused = ^{FrameStrobe, FrameData};

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) r_strobe_q <= '0;
        else         r_strobe_q <= FrameStrobe[NoFrames-1:0];
    end

    for (genvar k = 0; k < NoFrames; k++) begin : g_frame
        localparam int Lo = k * FrameBitsPerRow;
        localparam int W  = (NoConfigBits - Lo < FrameBitsPerRow) ? NoConfigBits - Lo
                                                                  : FrameBitsPerRow;
        localparam logic [W-1:0] RstImg = EMULATION_ENABLE ? EMULATION_CONFIG[Lo +: W] : '0;

        logic [W-1:0] r_shadow;
        logic [W-1:0] r_active;
        logic         r_loaded;

        // Commit copies the pre-edge shadow; a same-edge capture wins the loaded flag.
        always_ff @(posedge CLK or negedge resetn) begin
            if (!resetn) begin
                r_shadow <= RstImg;
                r_active <= RstImg;
                r_loaded <= 1'b0;
            end else begin
                if (commit)    r_active <= r_shadow;
                if (w_rise[k]) r_shadow <= FrameData[W-1:0];
                if (w_rise[k]) r_loaded <= 1'b1;
                else if (commit) r_loaded <= 1'b0;
            end
        end

        assign w_frame[k]            = FrameBitsPerRow'(r_shadow);
        assign frame_loaded[k]       = r_loaded;
        assign ConfigBits[Lo +: W]   = r_active;
        assign ConfigBits_N[Lo +: W] = ~r_active;
    end

    assign all_loaded = &frame_loaded;

    rb_state_t                r_state;
    rb_state_t                w_state_nxt;
    logic [RbW-1:0]           r_rb_idx;
    logic [FrameBitsPerRow-1:0] r_rb_data;
    logic                     r_rb_err;
    logic [FrameBitsPerRow-1:0] w_rb_sel;
    logic                     w_rb_oor;

    assign w_rb_oor = (int'(r_rb_idx) >= NoFrames);

    always_comb begin
        w_rb_sel = '0;
        for (int i = 0; i < NoFrames; i++)
            if (r_rb_idx == RbW'(i)) w_rb_sel = w_frame[i];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (rb_req) w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_rb_idx  <= '0;
            r_rb_data <= '0;
            r_rb_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && rb_req) r_rb_idx <= rb_frame;
            // Sampled before this edge's capture, so a racing write is not returned.
            if (r_state == S_READ) begin
                r_rb_data <= w_rb_oor ? '0 : w_rb_sel;
                r_rb_err  <= w_rb_oor;
            end
        end
    end

    assign rb_busy  = (r_state != S_IDLE);
    assign rb_valid = (r_state == S_RESP);
    assign rb_data  = r_rb_data;
    assign rb_err   = r_rb_err;

endmodule

// File: tb/tb_frame_config_mem_shadow.sv
// Random + directed bench for frame_config_mem_shadow; a frame-level reference model
// predicts active config, load flags and readback responses every cycle.
module tb_frame_config_mem_shadow;

    logic        CLK = 1'b0;
    logic        resetn;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        commit, rb_req;
    logic [4:0]  rb_frame;
    logic        rb_busy, rb_valid, rb_err, all_loaded;
    logic [31:0] rb_data;
    logic [1:0]  frame_loaded;
    logic [63:0] ConfigBits, ConfigBits_N;

    logic [31:0] u1_data;
    logic [19:0] u1_strobe;
    logic        u1_commit, u1_req;
    logic [4:0]  u1_frame;
    logic        u1_busy, u1_valid, u1_err, u1_all;
    logic [31:0] u1_rbd;
    logic [1:0]  u1_ld;
    logic [39:0] u1_cfg, u1_cfgn;

    logic        u2_busy, u2_valid, u2_err, u2_all;
    logic [31:0] u2_rbd;
    logic [1:0]  u2_ld;
    logic [63:0] u2_cfg, u2_cfgn;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    frame_config_mem_shadow u0 (
        .CLK(CLK), .resetn(resetn), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .commit(commit), .rb_req(rb_req), .rb_frame(rb_frame), .rb_busy(rb_busy),
        .rb_valid(rb_valid), .rb_data(rb_data), .rb_err(rb_err),
        .frame_loaded(frame_loaded), .all_loaded(all_loaded),
        .ConfigBits(ConfigBits), .ConfigBits_N(ConfigBits_N));

    frame_config_mem_shadow #(.NoConfigBits(40), .EMULATION_ENABLE(1'b1),
                              .EMULATION_CONFIG(40'hEF_0123_4567)) u1 (
        .CLK(CLK), .resetn(resetn), .FrameData(u1_data), .FrameStrobe(u1_strobe),
        .commit(u1_commit), .rb_req(u1_req), .rb_frame(u1_frame), .rb_busy(u1_busy),
        .rb_valid(u1_valid), .rb_data(u1_rbd), .rb_err(u1_err),
        .frame_loaded(u1_ld), .all_loaded(u1_all),
        .ConfigBits(u1_cfg), .ConfigBits_N(u1_cfgn));

    frame_config_mem_shadow #(.EMULATION_ENABLE(1'b1),
                              .EMULATION_CONFIG(64'hDEAD_BEEF_0123_4567)) u2 (
        .CLK(CLK), .resetn(resetn), .FrameData(u1_data), .FrameStrobe(u1_strobe),
        .commit(u1_commit), .rb_req(u1_req), .rb_frame(u1_frame), .rb_busy(u2_busy),
        .rb_valid(u2_valid), .rb_data(u2_rbd), .rb_err(u2_err),
        .frame_loaded(u2_ld), .all_loaded(u2_all),
        .ConfigBits(u2_cfg), .ConfigBits_N(u2_cfgn));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: shadow/active as flat 64-bit images, readback as a countdown
    logic [63:0] m_sh, m_act;
    logic [1:0]  m_ld;
    logic [19:0] m_prev;
    int          m_left;
    int          m_idx;
    logic [31:0] m_rbd;
    logic        m_rbe;

    task automatic model_reset();
        m_sh = '0; m_act = '0; m_ld = '0; m_prev = '0;
        m_left = 0; m_idx = 0; m_rbd = '0; m_rbe = 1'b0;
    endtask

    task automatic model_edge();
        logic [19:0] rise;
        logic [63:0] sh_new;
        rise = FrameStrobe & ~m_prev;
        if (m_left == 2) begin
            m_rbe  = (m_idx >= 2);
            m_rbd  = m_rbe ? 32'h0 : m_sh[m_idx*32 +: 32];
            m_left = 1;
        end else if (m_left == 1) begin
            m_left = 0;
        end else if (rb_req) begin
            m_left = 2;
            m_idx  = int'(rb_frame);
        end
        if (commit) begin
            m_act = m_sh;
            m_ld  = '0;
        end
        sh_new = m_sh;
        for (int k = 0; k < 2; k++)
            if (rise[k]) begin
                sh_new[k*32 +: 32] = FrameData;
                m_ld[k] = 1'b1;
            end
        m_sh   = sh_new;
        m_prev = FrameStrobe;
    endtask

    task automatic check_all();
        chk("cfg",   ConfigBits, m_act);
        chk("cfg_n", ConfigBits_N, ~m_act);
        chk("loaded", 64'(frame_loaded), 64'(m_ld));
        chk("all_loaded", 64'(all_loaded), 64'(&m_ld));
        chk("rb_busy", 64'(rb_busy), 64'(m_left > 0));
        chk("rb_valid", 64'(rb_valid), 64'(m_left == 1));
        chk("rb_data", 64'(rb_data), 64'(m_rbd));
        chk("rb_err", 64'(rb_err), 64'(m_rbe));
    endtask

    task automatic step(input logic [19:0] s, input logic [31:0] d, input logic c,
                        input logic r, input logic [4:0] f);
        @(negedge CLK);
        FrameStrobe = s; FrameData = d; commit = c; rb_req = r; rb_frame = f;
        model_edge();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    initial begin
        int nv;
        FrameStrobe = '0; FrameData = '0; commit = 0; rb_req = 0; rb_frame = '0;
        u1_strobe = '0; u1_data = '0; u1_commit = 0; u1_req = 0; u1_frame = '0;
        resetn = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_cfg", ConfigBits, 64'h0);
        chk("rst_cfg_n", ConfigBits_N, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_all", 64'(all_loaded), 64'h0);
        chk("rst_busy", 64'(rb_busy), 64'h0);
        chk("rst_emu64", u2_cfg, 64'hDEAD_BEEF_0123_4567);
        chk("rst_emu64_n", u2_cfgn, ~64'hDEAD_BEEF_0123_4567);
        chk("rst_emu40", 64'(u1_cfg), 64'h00EF_0123_4567);
        @(negedge CLK);
        resetn = 1'b1;

        // 40-bit instance: frame 1 keeps only 8 real bits
        @(negedge CLK); u1_strobe = 20'h2; u1_data = 32'hFFFF_FFFF;
        @(negedge CLK); u1_strobe = '0; u1_commit = 1'b1;
        @(negedge CLK); u1_commit = 1'b0;
        @(posedge CLK); #1;
        chk("u1_hi", 64'(u1_cfg[39:32]), 64'hFF);
        chk("u1_lo", 64'(u1_cfg[31:0]), 64'h0123_4567);
        @(negedge CLK); u1_req = 1'b1; u1_frame = 5'd1;
        @(posedge CLK); #1;
        chk("u1_lat1", 64'(u1_valid), 64'h0);
        @(negedge CLK); u1_req = 1'b0;
        @(posedge CLK); #1;
        chk("u1_lat2", 64'(u1_valid), 64'h1);
        chk("u1_rbd", 64'(u1_rbd), 64'hFF);
        @(posedge CLK); #1;
        chk("u1_vpulse", 64'(u1_valid), 64'h0);

        // staged load: nothing goes live until commit
        repeat (5) step(20'h1, 32'hA5A5_A5A5, 0, 0, 0);
        step(20'h2, 32'h0F0F_0F0F, 0, 0, 0);
        step(20'h0, 32'h0, 0, 0, 0);
        chk("pre_commit", ConfigBits, 64'h0);
        chk("ld_11", 64'(frame_loaded), 64'h3);
        step(20'h0, 32'h0, 1, 0, 0);
        chk("post_commit", ConfigBits, 64'h0F0F_0F0F_A5A5_A5A5);
        chk("ld_00", 64'(frame_loaded), 64'h0);

        // commit and capture on the same edge
        step(20'h1, 32'h1, 1, 0, 0);
        chk("same_act", ConfigBits, 64'h0F0F_0F0F_A5A5_A5A5);
        chk("same_ld0", 64'(frame_loaded[0]), 64'h1);
        step(20'h0, 32'h0, 1, 0, 0);
        chk("commit2", 64'(ConfigBits[31:0]), 64'h1);

        // out-of-range readback and requests while busy
        nv = 0;
        step(20'h0, 32'h0, 0, 1, 5'd5); nv += int'(rb_valid);
        step(20'h0, 32'h0, 0, 1, 5'd0); nv += int'(rb_valid);
        chk("err_flag", 64'(rb_err), 64'h1);
        chk("err_data", 64'(rb_data), 64'h0);
        step(20'h0, 32'h0, 0, 1, 5'd1); nv += int'(rb_valid);
        step(20'h0, 32'h0, 0, 0, 5'd0); nv += int'(rb_valid);
        chk("one_valid", 64'(nv), 64'h1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [19:0] s;
            logic [4:0]  f;
            s = 20'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) s = s | (20'($urandom) & 20'hFFFFC);
            f = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 2));
            step(s, $urandom, ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), f);
        end

        // reset while a readback is in READ
        step(20'h0, 32'h0, 0, 0, 0);
        step(20'h0, 32'h0, 0, 0, 0);
        step(20'h0, 32'h0, 0, 0, 0);
        step(20'h1, 32'hCAFE_F00D, 0, 0, 0);
        step(20'h0, 32'h0, 0, 1, 5'd0);
        chk("mid_busy", 64'(rb_busy), 64'h1);
        @(negedge CLK);
        rb_req = 1'b0; FrameStrobe = '0; FrameData = '0; commit = 1'b0;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("abort_busy", 64'(rb_busy), 64'h0);
        chk("abort_valid", 64'(rb_valid), 64'h0);
        nv = 0;
        repeat (3) begin
            @(posedge CLK); #1;
            nv += int'(rb_valid);
        end
        @(negedge CLK);
        resetn = 1'b1;
        repeat (2) begin
            @(posedge CLK); #1;
            nv += int'(rb_valid);
        end
        chk("abort_no_valid", 64'(nv), 64'h0);
        step(20'h0, 32'h0, 1, 0, 0);
        chk("shadow_restored", ConfigBits, 64'h0);
        step(20'h0, 32'h0, 0, 1, 5'd0);
        step(20'h0, 32'h0, 0, 0, 5'd0);
        chk("rb_after_rst", 64'(rb_data), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
